// File: rtl/psd_square.sv
// Sequential unsigned squarer: xin*xin by shift-and-add, one multiplier bit per clock.
// A start/stop handshake latches the operand and loads the result register.
module psd_square #(
    parameter int NBITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NBITS-1:0]     xin,
    output logic [2*NBITS-1:0]   sq,
    output logic                 busy,
    output logic                 done
);

    localparam int CNTW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [2*NBITS-1:0]   areg_reg;
    logic [NBITS-1:0]     mreg_reg;
    logic [2*NBITS-1:0]   acc_reg;
    logic [CNTW-1:0]      cnt_reg;
    logic [2*NBITS-1:0]   sq_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A start in any state (re)launches; the last iteration edge moves to DONE.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = RUN;
        end else if (state_reg == RUN && cnt_reg == LAST) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sq_reg   <= '0;
            acc_reg  <= '0;
            areg_reg <= '0;
            mreg_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            // Stop captures the accumulator as it was before this edge.
            if (stop) begin
                sq_reg <= acc_reg;
            end
            if (start) begin
                areg_reg <= {{NBITS{1'b0}}, xin};
                mreg_reg <= xin;
                acc_reg  <= '0;
                cnt_reg  <= '0;
            end else if (state_reg == RUN) begin
                if (mreg_reg[0]) begin
                    acc_reg <= acc_reg + areg_reg;
                end
                areg_reg <= areg_reg << 1;
                mreg_reg <= mreg_reg >> 1;
                cnt_reg  <= cnt_reg + CNTW'(1);
            end
        end
    end

    assign sq   = sq_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule
